// File: rtl/dtcore32_scoreboard_hazard_unit.sv
// dtcore32 hazard unit: per-register latency scoreboard for ID stalls,
// multi-stage EX forwarding, ID bypass from WB, and trap/branch flush vector.
module dtcore32_scoreboard_hazard_unit #(
    parameter int NUM_FWD_STAGES = 3,
    parameter int LAT_W          = 3,
    parameter int CNT_W          = 32,
    localparam int N             = NUM_FWD_STAGES,
    localparam int FW            = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hold_i,
    input  logic             id_issue_i,
    input  logic             id_rd_we_i,
    input  logic [4:0]       id_rd_addr_i,
    input  logic [LAT_W-1:0] id_rd_lat_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rs1_addr_i,
    input  logic [4:0]       ex_rs2_addr_i,
    input  logic [5*N-1:0]   stg_rd_addr_i,
    input  logic [N-1:0]     stg_rd_we_i,
    input  logic             ex_pc_src_i,
    input  logic [N+1:0]     trap_valid_i,
    output logic [FW-1:0]    ex_fwd_a_o,
    output logic [FW-1:0]    ex_fwd_b_o,
    output logic             id_fwd_a_o,
    output logic             id_fwd_b_o,
    output logic [N+1:0]     flush_o,
    output logic             if_stall_o,
    output logic             id_stall_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    input  logic             clr_stall_cnt_i
);

    logic [LAT_W-1:0] sb_q   [31:1];
    logic [LAT_W-1:0] sb_d   [31:1];
    logic [LAT_W-1:0] sb_dec [31:1];
    logic [31:0]      busy;
    logic             issue_we;
    logic             hit;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign issue_we = id_issue_i & id_rd_we_i & (id_rd_addr_i != 5'd0);

    // Scoreboard next state: count down unless frozen, WAW-safe max on issue,
    // WB trap wipes everything (overrides a same-cycle issue).
    always_comb begin
        for (int r = 1; r < 32; r++) begin
            sb_dec[r] = (hold_i || sb_q[r] == '0) ? sb_q[r] : sb_q[r] - 1'b1;
            sb_d[r]   = sb_dec[r];
            if (issue_we && id_rd_addr_i == 5'(r))
                sb_d[r] = (id_rd_lat_i > sb_dec[r]) ? id_rd_lat_i : sb_dec[r];
            if (trap_valid_i[N+1])
                sb_d[r] = '0;
        end
    end

    // Scoreboard registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 1; r < 32; r++) sb_q[r] <= '0;
        end else begin
            for (int r = 1; r < 32; r++) sb_q[r] <= sb_d[r];
        end
    end

    // Busy view indexed by architectural register; x0 is never busy
    always_comb begin
        busy[0] = 1'b0;
        for (int r = 1; r < 32; r++) busy[r] = |sb_q[r];
    end

    assign hit        = (id_rs1_used_i & busy[id_rs1_addr_i]) |
                        (id_rs2_used_i & busy[id_rs2_addr_i]);
    // A redirect in EX kills the ID instruction, so its hazard is moot
    assign id_stall_o = hit & ~ex_pc_src_i;
    assign if_stall_o = id_stall_o;

    // Youngest matching post-EX stage wins; scan oldest to youngest so the
    // last assignment is the lowest index.
    function automatic logic [FW-1:0] fwd_sel(input logic [4:0] rs);
        logic [FW-1:0] sel;
        sel = '0;
        for (int k = N - 1; k >= 0; k--)
            if (stg_rd_we_i[k] && stg_rd_addr_i[5*k +: 5] == rs && rs != 5'd0)
                sel = FW'(k + 1);
        return sel;
    endfunction

    assign ex_fwd_a_o = fwd_sel(ex_rs1_addr_i);
    assign ex_fwd_b_o = fwd_sel(ex_rs2_addr_i);

    assign id_fwd_a_o = stg_rd_we_i[N-1] && (id_rs1_addr_i == stg_rd_addr_i[5*(N-1) +: 5])
                        && (id_rs1_addr_i != 5'd0);
    assign id_fwd_b_o = stg_rd_we_i[N-1] && (id_rs2_addr_i == stg_rd_addr_i[5*(N-1) +: 5])
                        && (id_rs2_addr_i != 5'd0);

    // A trap in any stage flushes that stage and everything younger
    for (genvar j = 1; j < N + 2; j++) begin : g_flush
        if (j == 1) begin : g_ex
            assign flush_o[j] = (|trap_valid_i[N+1:j]) | ex_pc_src_i;
        end else begin : g_post
            assign flush_o[j] = |trap_valid_i[N+1:j];
        end
    end
    // An ID trap behind a stall is not yet committed to, so it waits
    assign flush_o[0] = ex_pc_src_i | (trap_valid_i[0] & ~id_stall_o) | (|trap_valid_i[N+1:1]);

    // Stall counter next state: clear wins, otherwise saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_stall_cnt_i)
            cnt_d = '0;
        else if (id_stall_o && !hold_i && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
    end

    // Stall counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign stall_cnt_o = cnt_q;

    // A forwarded producer must already be outside its scoreboard window
    a_fwd_a_safe: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ex_fwd_a_o == '0) || !busy[ex_rs1_addr_i]);
    a_fwd_b_safe: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ex_fwd_b_o == '0) || !busy[ex_rs2_addr_i]);

endmodule

// File: tb/tb_dtcore32_scoreboard_hazard_unit.sv
// Bench for dtcore32_scoreboard_hazard_unit: directed scenarios plus random
// traffic against a behavioural model of the hazard rules.
module tb_dtcore32_scoreboard_hazard_unit;
    localparam int N     = 3;
    localparam int LAT_W = 3;
    localparam int CNT_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             hold_i, id_issue_i, id_rd_we_i;
    logic [4:0]       id_rd_addr_i;
    logic [LAT_W-1:0] id_rd_lat_i;
    logic [4:0]       id_rs1_addr_i, id_rs2_addr_i;
    logic             id_rs1_used_i, id_rs2_used_i;
    logic [4:0]       ex_rs1_addr_i, ex_rs2_addr_i;
    logic [5*N-1:0]   stg_rd_addr_i;
    logic [N-1:0]     stg_rd_we_i;
    logic             ex_pc_src_i;
    logic [N+1:0]     trap_valid_i;
    logic [1:0]       ex_fwd_a_o, ex_fwd_b_o;
    logic             id_fwd_a_o, id_fwd_b_o;
    logic [N+1:0]     flush_o;
    logic             if_stall_o, id_stall_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             clr_stall_cnt_i;

    dtcore32_scoreboard_hazard_unit #(.NUM_FWD_STAGES(N), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .hold_i(hold_i),
        .id_issue_i(id_issue_i), .id_rd_we_i(id_rd_we_i), .id_rd_addr_i(id_rd_addr_i),
        .id_rd_lat_i(id_rd_lat_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_rs1_addr_i(ex_rs1_addr_i), .ex_rs2_addr_i(ex_rs2_addr_i),
        .stg_rd_addr_i(stg_rd_addr_i), .stg_rd_we_i(stg_rd_we_i), .ex_pc_src_i(ex_pc_src_i),
        .trap_valid_i(trap_valid_i), .ex_fwd_a_o(ex_fwd_a_o), .ex_fwd_b_o(ex_fwd_b_o),
        .id_fwd_a_o(id_fwd_a_o), .id_fwd_b_o(id_fwd_b_o), .flush_o(flush_o),
        .if_stall_o(if_stall_o), .id_stall_o(id_stall_o), .stall_cnt_o(stall_cnt_o),
        .clr_stall_cnt_i(clr_stall_cnt_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int rem [32];   // cycles each register still blocks a reader
    int cnt_m;
    logic obs_stall;
    logic [31:0] obs_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        hold_i = 0; id_issue_i = 0; id_rd_we_i = 0; id_rd_addr_i = 0; id_rd_lat_i = 0;
        id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rs1_used_i = 0; id_rs2_used_i = 0;
        ex_rs1_addr_i = 0; ex_rs2_addr_i = 0; stg_rd_addr_i = 0; stg_rd_we_i = 0;
        ex_pc_src_i = 0; trap_valid_i = 0; clr_stall_cnt_i = 0;
    endtask

    function automatic int stg_addr(int k);
        logic [5*N-1:0] v;
        v = stg_rd_addr_i;
        return int'(v[5*k +: 5]);
    endfunction

    function automatic int exp_fwd(int rs);
        for (int k = 0; k < N; k++)
            if (stg_rd_we_i[k] && stg_addr(k) == rs && rs != 0) return k + 1;
        return 0;
    endfunction

    function automatic bit blocked(int rs, bit used);
        return used && rs != 0 && rem[rs] > 0;
    endfunction

    task automatic reset_model();
        for (int r = 0; r < 32; r++) rem[r] = 0;
        cnt_m = 0;
    endtask

    // Check every output against the model, then advance one clock
    task automatic step();
        bit e_stall, any_hi;
        logic [N+1:0] e_fl;
        #1;
        e_stall = (blocked(id_rs1_addr_i, id_rs1_used_i) || blocked(id_rs2_addr_i, id_rs2_used_i))
                  && !ex_pc_src_i;
        for (int j = 0; j < N + 2; j++) begin
            any_hi = 0;
            for (int i = (j == 0 ? 1 : j); i < N + 2; i++) if (trap_valid_i[i]) any_hi = 1;
            if (j == 0)      e_fl[j] = ex_pc_src_i | (trap_valid_i[0] & ~e_stall) | any_hi;
            else if (j == 1) e_fl[j] = any_hi | ex_pc_src_i;
            else             e_fl[j] = any_hi;
        end
        chk("id_stall", id_stall_o, e_stall);
        chk("if_stall", if_stall_o, e_stall);
        chk("ex_fwd_a", ex_fwd_a_o, exp_fwd(ex_rs1_addr_i));
        chk("ex_fwd_b", ex_fwd_b_o, exp_fwd(ex_rs2_addr_i));
        chk("id_fwd_a", id_fwd_a_o, stg_rd_we_i[N-1] && stg_addr(N-1) == id_rs1_addr_i && id_rs1_addr_i != 0);
        chk("id_fwd_b", id_fwd_b_o, stg_rd_we_i[N-1] && stg_addr(N-1) == id_rs2_addr_i && id_rs2_addr_i != 0);
        chk("flush", flush_o, e_fl);
        chk("stall_cnt", stall_cnt_o, cnt_m);
        obs_stall = id_stall_o;
        obs_cnt   = 32'(stall_cnt_o);
        @(posedge clk_i);
        if (trap_valid_i[N+1]) begin
            for (int r = 0; r < 32; r++) rem[r] = 0;
        end else begin
            if (!hold_i) for (int r = 1; r < 32; r++) if (rem[r] > 0) rem[r]--;
            if (id_issue_i && id_rd_we_i && id_rd_addr_i != 0 && int'(id_rd_lat_i) > rem[id_rd_addr_i])
                rem[id_rd_addr_i] = int'(id_rd_lat_i);
        end
        if (clr_stall_cnt_i) cnt_m = 0;
        else if (e_stall && !hold_i && cnt_m < CMAX) cnt_m++;
        #1;
    endtask

    task automatic issue(input int rd, input int lat);
        idle();
        id_issue_i = 1; id_rd_we_i = 1; id_rd_addr_i = 5'(rd); id_rd_lat_i = 3'(lat);
        step();
    endtask

    function automatic logic [4:0] far_reg();
        int r;
        r = $urandom_range(0, 16);
        return (r == 0) ? 5'd0 : 5'(15 + r);
    endfunction

    int n;

    initial begin
        idle();
        rst_ni = 0;
        reset_model();
        #3;
        chk("rst_cnt", stall_cnt_o, 0);
        chk("rst_stall", id_stall_o, 0);
        chk("rst_flush", flush_o, 0);
        chk("rst_fwd", ex_fwd_a_o, 0);
        #9 rst_ni = 1;
        @(posedge clk_i); #1;

        // Load use: one stall, then forward from MEM2
        issue(5, 1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            idle(); id_rs1_addr_i = 5; id_rs1_used_i = 1; step();
            if (obs_stall) n++;
        end
        chk("lu_stalls", n, 1);
        idle(); ex_rs1_addr_i = 5; stg_rd_addr_i[9:5] = 5; stg_rd_we_i = 3'b010; step();
        chk("lu_fwd", ex_fwd_a_o, 2);

        // CSR use: three stalls, five with a two-cycle hold inside
        issue(7, 3);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            idle(); id_rs2_addr_i = 7; id_rs2_used_i = 1; step();
            if (obs_stall) n++;
        end
        chk("csr_stalls", n, 3);
        issue(7, 3);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            idle(); id_rs2_addr_i = 7; id_rs2_used_i = 1; hold_i = (i == 1 || i == 2);
            step();
            if (obs_stall) n++;
        end
        chk("csr_hold_stalls", n, 5);

        // WAW: shorter re-issue must not shorten the window
        issue(3, 3);
        issue(3, 1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            idle(); id_rs1_addr_i = 3; id_rs1_used_i = 1; step();
            if (obs_stall) n++;
        end
        chk("waw_stalls", n, 2);

        // Forward priority
        idle(); ex_rs1_addr_i = 9; stg_rd_addr_i = {5'd9, 5'd9, 5'd9}; stg_rd_we_i = 3'b111; step();
        chk("fwd_young", ex_fwd_a_o, 1);
        stg_rd_we_i = 3'b110; step();
        chk("fwd_mid", ex_fwd_a_o, 2);
        ex_rs1_addr_i = 0; step();
        chk("fwd_x0", ex_fwd_a_o, 0);

        // Flush vector and WB trap clearing the scoreboard
        idle(); trap_valid_i = 5'b00100; step();
        chk("flush_mem1", flush_o, 5'b00111);
        issue(10, 3);
        idle(); ex_pc_src_i = 1; id_rs1_addr_i = 10; id_rs1_used_i = 1; step();
        chk("flush_br", flush_o, 5'b00011);
        chk("br_nostall", id_stall_o, 0);
        idle(); trap_valid_i = 5'b10000; id_rs1_addr_i = 10; id_rs1_used_i = 1; step();
        chk("wb_pre_stall", obs_stall, 1);
        idle(); id_rs1_addr_i = 10; id_rs1_used_i = 1; step();
        chk("wb_cleared", obs_stall, 0);

        // Perf counter: 10 stalls, clear during a stall, then saturation
        idle(); clr_stall_cnt_i = 1; step();
        issue(11, 7);
        for (int i = 0; i < 10; i++) begin
            idle(); id_rs1_addr_i = 11; id_rs1_used_i = 1;
            id_issue_i = 1; id_rd_we_i = 1; id_rd_addr_i = 11; id_rd_lat_i = 7;
            step();
        end
        idle(); id_rs1_addr_i = 11; id_rs1_used_i = 1; clr_stall_cnt_i = 1; step();
        chk("cnt_ten", obs_cnt, 10);
        idle(); step();
        chk("cnt_clr", obs_cnt, 0);
        for (int i = 0; i < CMAX + 4; i++) begin
            idle(); id_rs1_addr_i = 11; id_rs1_used_i = 1;
            id_issue_i = 1; id_rd_we_i = 1; id_rd_addr_i = 11; id_rd_lat_i = 7;
            step();
        end
        idle(); step();
        chk("cnt_sat", obs_cnt, CMAX);

        // Random traffic; EX/stage registers kept apart from issued ones
        for (int c = 0; c < 3000; c++) begin
            idle();
            hold_i          = ($urandom_range(0, 3) == 0);
            id_issue_i      = 1'($urandom);
            id_rd_we_i      = 1'($urandom);
            id_rd_addr_i    = 5'($urandom_range(0, 15));
            id_rd_lat_i     = 3'($urandom);
            id_rs1_addr_i   = 5'($urandom);
            id_rs2_addr_i   = 5'($urandom);
            id_rs1_used_i   = 1'($urandom);
            id_rs2_used_i   = 1'($urandom);
            ex_rs1_addr_i   = far_reg();
            ex_rs2_addr_i   = far_reg();
            for (int k = 0; k < N; k++) stg_rd_addr_i[5*k +: 5] = far_reg();
            stg_rd_we_i     = 3'($urandom);
            ex_pc_src_i     = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < N + 2; k++) trap_valid_i[k] = ($urandom_range(0, 24) == 0);
            clr_stall_cnt_i = ($urandom_range(0, 60) == 0);
            if (c % 8 == 0) begin
                id_rs2_addr_i = 5'(stg_addr(N - 1));
                id_rs2_used_i = 1;
            end
            step();
        end

        // Asynchronous reset in mid-window
        issue(12, 7);
        idle(); id_rs1_addr_i = 12; id_rs1_used_i = 1; step();
        #2 rst_ni = 0;
        #1;
        reset_model();
        chk("arst_stall", id_stall_o, 0);
        chk("arst_cnt", stall_cnt_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1;
        for (int i = 0; i < 4; i++) begin
            idle(); id_rs1_addr_i = 12; id_rs1_used_i = 1; step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
